led_blink_ctrl: RTL and testbench
=================================

Name: led_blink_ctrl

Overview:
Multi-channel LED blink controller, the parametrised successor to the single-LED fixed-rate blinker. A shared prescaler derives a slow tick from the system clock. Each channel is independently loaded with a mode (off, on, blink, one-shot pulse) and a half-period in ticks. Sits between board-level LED pins and a simple control source (top-level constants, switches or a register block).

Parameters:
FREQ, 50_000_000, system clock frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; DIV = FREQ/TICK_HZ (integer), elaboration error if DIV < 1
CHANNELS, 4, number of independent LED channels (1..32)
PER_W, 16, width of per-channel half-period field, in ticks

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
load_i  input  CHANNELS  per-channel load strobe; bit n captures channel n config
mode_i  input  2*CHANNELS  per-channel mode, channel n at [2n+1:2n]; 0 OFF, 1 ON, 2 BLINK, 3 PULSE
half_i  input  PER_W*CHANNELS  per-channel half-period in ticks, channel n at [PER_W*n +: PER_W]
led_o  output  CHANNELS  LED drive, registered
done_o  output  CHANNELS  one-cycle pulse when a PULSE completes
tick_o  output  1  one-cycle prescaler tick, exported for other blocks

Behaviour:
- Reset (async assert, sync release on clk_i): prescaler count 0, tick_o 0, all channels mode OFF, half 1, channel count 0, led_o 0, done_o 0.
- Prescaler: count 0..DIV-1 with wrap. tick_o is high for exactly the cycle in which count == DIV-1, giving period DIV cycles. DIV == 1 makes tick_o constant high after reset.
- Load: on a cycle with load_i[n]=1, mode_i/half_i for n are registered. Channel count is cleared. led_o[n] updates on the next edge: OFF→0, ON→1, BLINK→1, PULSE→1. half_i == 0 is stored as 1. Other channels are unaffected.
- Config persists until the next load. Inputs are ignored when load_i[n]=0.
- Channel count advances only on tick cycles, and only in BLINK and PULSE. OFF/ON hold count 0.
- BLINK: on a tick with count == half-1, toggle led_o[n] and clear count; otherwise increment. Full period = 2*half ticks. Free-runs indefinitely.
- PULSE: on a tick with count == half-1: led_o[n] goes to 0, done_o[n] pulses for one cycle, and the channel mode becomes OFF (one-shot, no retrigger without a new load). Pulse width is half ticks, measured from the first tick after load.
- Load and tick in the same cycle: load wins. The tick is not counted for that channel, and the count is 0 after the edge.
- Re-load mid-operation (any mode, including an active PULSE): restarts cleanly from the new config. No done_o for the aborted pulse.
- Reset mid-operation: immediate return to reset state. No done_o is generated.
- Width rules: channel count is PER_W bits and never exceeds half-1, so no overflow. Prescaler count is $clog2(DIV) bits, minimum 1.
- Latency: load to led_o is 1 cycle. The final PULSE tick to led_o=0 and done_o=1 is 1 cycle, and both change on the same edge.

Decomposition:
- Package led_blink_pkg: mode enum (MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_PULSE=3) and the 2-bit mode typedef.
- Sub-module tick_gen: params FREQ, TICK_HZ; ports clk_i, rst_i, tick_o. It is reusable across the codebase.
- Channel logic is a generate loop in led_blink_ctrl. No further sub-module is needed.

Test Plan:
- Bench parameters: FREQ=1000, TICK_HZ=100 (DIV=10), CHANNELS=4, PER_W=8.
- Reset release → tick_o pulses every 10 cycles, first pulse 10 cycles after release. led_o=0, done_o=0.
- Load ch0 BLINK half=3 → led_o[0]=1 next cycle, toggles after every 3rd tick (30 clk), period 60 clk, sustained 10 periods.
- Load ch1 PULSE half=2 → led_o[1]=1 next cycle. After the 2nd tick, led_o[1]=0 and done_o[1]=1 for exactly one cycle. Then it stays 0 with no further done_o.
- Load ch2 ON, then ch3 BLINK half=0 → led_o[2] steady 1. ch3 toggles on every tick (half treated as 1). ch0/ch1 timing is undisturbed.
- Load ch0 BLINK coinciding with tick_o=1 → count 0 after the edge; first toggle after 3 further ticks.
- Assert rst_i asynchronously mid-PULSE on ch1 → led_o and done_o go to 0 without a clock edge. After release, all channels are OFF and tick timing restarts from 0.

Source files
------------

// File: rtl/led_blink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_blink_pkg                                               |
// | Purpose: Shared types for the LED blink controller: the per-channel  |
// |          2-bit mode encoding.                                        |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package led_blink_pkg;

   // Raw 2-bit mode field as it appears on the mode_i bus.
   typedef logic [1:0] mode_t;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PULSE = 2'd3
   } mode_e;

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_blink_ctrl_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tick_gen                                                    |
// | Purpose: Divides the system clock by DIV = FREQ/TICK_HZ and emits a  |
// |          registered one-cycle tick once per DIV cycles.              |
// | Ports  : clk_i  - system clock                                       |
// |          rst_i  - asynchronous active-high reset                     |
// |          tick_o - high in the cycle where the count equals DIV-1     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tick_gen #(
   parameter int FREQ    = 50_000_000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int DIV   = FREQ / TICK_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   if (DIV < 1) begin : g_div_check
      $error("tick_gen: FREQ/TICK_HZ must be at least 1");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // The tick is registered from the next count value, so tick_q is high
   // exactly while cnt_q == LAST. With DIV == 1 the count is pinned at 0
   // and the tick stays high from the first edge after reset.
   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tick_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule : tick_gen
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_blink_ctrl                                              |
// | Purpose: Multi-channel LED blink controller. A shared prescaler tick |
// |          clocks per-channel OFF / ON / BLINK / one-shot PULSE logic. |
// | Ports  : clk_i   - system clock                                      |
// |          rst_i   - asynchronous active-high reset                    |
// |          load_i  - per-channel config load strobe                    |
// |          mode_i  - per-channel mode, channel n at [2n+1:2n]          |
// |          half_i  - per-channel half-period in ticks                  |
// |          led_o   - registered LED drive                              |
// |          done_o  - one-cycle pulse when a PULSE completes            |
// |          tick_o  - prescaler tick, exported                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module led_blink_ctrl
   import led_blink_pkg::*;
#(
   parameter int FREQ     = 50_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int CHANNELS = 4,
   parameter int PER_W    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [CHANNELS-1:0]       load_i,
   input  logic [2*CHANNELS-1:0]     mode_i,
   input  logic [PER_W*CHANNELS-1:0] half_i,
   output logic [CHANNELS-1:0]       led_o,
   output logic [CHANNELS-1:0]       done_o,
   output logic                      tick_o
);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_chan_check
      $error("led_blink_ctrl: CHANNELS must be in 1..32");
   end

   tick_gen #(
      .FREQ    (FREQ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick_o)
   );

   for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
      mode_e             mode_q, mode_d;
      logic [PER_W-1:0]  half_q, half_d;
      logic [PER_W-1:0]  cnt_q,  cnt_d;
      logic              led_q,  led_d;
      logic              done_q, done_d;
      mode_e             mode_in;
      logic [PER_W-1:0]  half_in;

      assign mode_in = mode_e'(mode_i[2*n +: 2]);
      assign half_in = half_i[PER_W*n +: PER_W];

      always_comb begin
         mode_d = mode_q;
         half_d = half_q;
         cnt_d  = cnt_q;
         led_d  = led_q;
         done_d = 1'b0;
         // A load takes priority over a coincident tick: the tick is simply
         // not counted and the channel starts from count 0.
         if (load_i[n]) begin
            mode_d = mode_in;
            half_d = (half_in == '0) ? PER_W'(1) : half_in;
            cnt_d  = '0;
            led_d  = (mode_in != MODE_OFF);
         end else if (tick_o && (mode_q == MODE_BLINK || mode_q == MODE_PULSE)) begin
            if (cnt_q == half_q - 1'b1) begin
               cnt_d = '0;
               if (mode_q == MODE_BLINK) begin
                  led_d = ~led_q;
               end else begin
                  // One-shot: drop to OFF so no retrigger without a new load.
                  led_d  = 1'b0;
                  done_d = 1'b1;
                  mode_d = MODE_OFF;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            mode_q <= MODE_OFF;
            half_q <= PER_W'(1);
            cnt_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
         end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            done_q <= done_d;
         end
      end

      assign led_o[n]  = led_q;
      assign done_o[n] = done_q;
   end

endmodule : led_blink_ctrl
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_led_blink_ctrl                                           |
// | Purpose: Self-checking bench for led_blink_ctrl. Expected outputs    |
// |          for each cycle are computed from closed-form tick arithmetic|
// |          and queued as stimulus is driven; a negedge monitor pops    |
// |          and compares them against the DUT.                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_led_blink_ctrl;

   localparam int CH  = 4;
   localparam int PW  = 8;
   localparam int DIV = 10;

   logic              clk_i  = 1'b0;
   logic              rst_i  = 1'b1;
   logic [CH-1:0]     load_i = '0;
   logic [2*CH-1:0]   mode_i = '0;
   logic [PW*CH-1:0]  half_i = '0;
   logic [CH-1:0]     led_o;
   logic [CH-1:0]     done_o;
   logic              tick_o;

   led_blink_ctrl #(
      .FREQ     (1000),
      .TICK_HZ  (100),
      .CHANNELS (CH),
      .PER_W    (PW)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load_i),
      .mode_i (mode_i),
      .half_i (half_i),
      .led_o  (led_o),
      .done_o (done_o),
      .tick_o (tick_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int            c;
      logic [CH-1:0] led;
      logic [CH-1:0] done;
      logic          tick;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: reset-release cycle and per-channel load record.
   int         R      = 0;
   bit         in_rst = 1'b1;
   int         L [CH];
   logic [1:0] M [CH];
   int         H [CH];

   // Number of tick cycles in [R, x]; ticks occur where (t-R)%DIV == DIV-1.
   function automatic int nt(int x);
      return (x - R + 1) / DIV;
   endfunction

   function automatic bit tick_at(int c);
      return (c >= R) && (((c - R) % DIV) == DIV - 1);
   endfunction

   function automatic exp_t model(int c);
      exp_t e;
      int   k;
      e.c = c; e.led = '0; e.done = '0; e.tick = 1'b0;
      if (!in_rst) begin
         e.tick = tick_at(c);
         for (int n = 0; n < CH; n++) begin
            k = nt(c - 1) - nt(L[n]);   // ticks seen since the load cycle
            case (M[n])
               2'd1:    e.led[n] = 1'b1;
               2'd2:    e.led[n] = ((k / H[n]) % 2) == 0;
               2'd3: begin
                  e.led[n]  = (k < H[n]);
                  e.done[n] = (k == H[n]) && tick_at(c - 1);
               end
               default: e.led[n] = 1'b0;
            endcase
         end
      end
      return e;
   endfunction

   exp_t mon_e;
   always @(negedge clk_i) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (mon_e.c !== cyc) begin
            errors++;
            $display("FAIL sb_align: monitor cycle %0d, entry cycle %0d", cyc, mon_e.c);
         end
         checks++;
         if (led_o !== mon_e.led) begin
            errors++;
            $display("FAIL led cyc=%0d: got %b want %b", cyc, led_o, mon_e.led);
         end
         checks++;
         if (done_o !== mon_e.done) begin
            errors++;
            $display("FAIL done cyc=%0d: got %b want %b", cyc, done_o, mon_e.done);
         end
         checks++;
         if (tick_o !== mon_e.tick) begin
            errors++;
            $display("FAIL tick cyc=%0d: got %b want %b", cyc, tick_o, mon_e.tick);
         end
      end
   end

   // One cycle of stimulus: queue this cycle's expectation, then drive the
   // load (captured at the edge ending this cycle) and record it.
   task automatic step(input logic [CH-1:0] ld, input logic [1:0] md, input logic [PW-1:0] hf);
      @(posedge clk_i); #2;
      sb.push_back(model(cyc));
      load_i = ld;
      for (int n = 0; n < CH; n++) begin
         if (ld[n]) begin
            mode_i[2*n +: 2]   = md;
            half_i[PW*n +: PW] = hf;
            L[n] = cyc;
            M[n] = md;
            H[n] = (hf == 0) ? 1 : int'(hf);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, 2'd0, '0);
   endtask

   task automatic release_rst();
      @(posedge clk_i); #2;
      sb.push_back(model(cyc));
      rst_i  = 1'b0;
      in_rst = 1'b0;
      R      = cyc;
      for (int n = 0; n < CH; n++) begin
         L[n] = cyc; M[n] = 2'd0; H[n] = 1;
      end
   endtask

   task automatic test_reset();
      rst_i  = 1'b1;
      in_rst = 1'b1;
      idle(3);
      release_rst();
      idle(35);
   endtask

   task automatic test_blink();
      step(4'b0001, 2'd2, 8'd3);
      idle(600);
   endtask

   task automatic test_pulse();
      step(4'b0010, 2'd3, 8'd2);
      idle(80);
   endtask

   task automatic test_on_and_fast();
      step(4'b0100, 2'd1, 8'd7);
      step(4'b1000, 2'd2, 8'd0);
      idle(100);
   endtask

   task automatic test_load_on_tick();
      while (!tick_at(cyc + 1)) idle(1);
      step(4'b0001, 2'd2, 8'd3);
      checks++;
      if (tick_o !== 1'b1) begin
         errors++;
         $display("FAIL load_on_tick: tick_o got %b want 1 in load cycle", tick_o);
      end
      idle(120);
   endtask

   task automatic test_reset_mid_pulse();
      step(4'b0010, 2'd3, 8'd5);
      idle(15);
      @(posedge clk_i); #2;
      rst_i  = 1'b1;
      in_rst = 1'b1;
      #1;
      checks++;
      if (led_o !== '0) begin
         errors++;
         $display("FAIL async_rst led: got %b want 0000", led_o);
      end
      checks++;
      if (done_o !== '0) begin
         errors++;
         $display("FAIL async_rst done: got %b want 0000", done_o);
      end
      checks++;
      if (tick_o !== 1'b0) begin
         errors++;
         $display("FAIL async_rst tick: got %b want 0", tick_o);
      end
      idle(3);
      release_rst();
      idle(70);
   endtask

   initial begin
      for (int n = 0; n < CH; n++) begin
         L[n] = 0; M[n] = 2'd0; H[n] = 1;
      end
      test_reset();
      test_blink();
      test_pulse();
      test_on_and_fast();
      test_load_on_tick();
      test_reset_mid_pulse();
      @(negedge clk_i); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_led_blink_ctrl
`default_nettype wire
